// File: rtl/rco_event_timer.sv
// Counts RCO pulses from counter4b up to a programmable terminal value and
// raises TICK/IRQ/OVR on each match, in periodic or one-shot mode.
module rco_event_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             oneshot_i,
  input  logic [WIDTH-1:0] term_i,
  input  logic             rco_i,
  input  logic             load_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             irq_o,
  output logic             ovr_o,
  output logic             busy_o,
  output logic             cfg_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             oneshot_q, oneshot_d;
  logic             tick_q, tick_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             cfg_err_q, cfg_err_d;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      term_q    <= '0;
      oneshot_q <= 1'b0;
      tick_q    <= 1'b0;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      term_q    <= term_d;
      oneshot_q <= oneshot_d;
      tick_q    <= tick_d;
      irq_q     <= irq_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    term_d    = term_q;
    oneshot_d = oneshot_q;
    tick_d    = 1'b0;
    irq_d     = irq_q;
    ovr_d     = ovr_q;
    cfg_err_d = 1'b0;

    // ACK clears first so that a coincident terminal match re-sets IRQ
    if (ack_i) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (start_i) begin
          if (term_i != '0) begin
            term_d    = term_i;
            oneshot_d = oneshot_i;
            count_d   = '0;
            state_d   = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (load_i) begin
          count_d = '0;
        end else if (rco_i) begin
          if (count_q == term_q - WIDTH'(1)) begin
            count_d = '0;
            tick_d  = 1'b1;
            irq_d   = 1'b1;
            if (irq_q && !ack_i) begin
              ovr_d = 1'b1;
            end
            if (oneshot_q) begin
              state_d = ST_DONE;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  assign count_o   = count_q;
  assign tick_o    = tick_q;
  assign irq_o     = irq_q;
  assign ovr_o     = ovr_q;
  assign busy_o    = busy_q;
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_rco_event_timer.sv
// Directed vector table plus hand-written sequences for rco_event_timer.
module tb_rco_event_timer;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset, start, stop, oneshot, rco, load, ack;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] count;
  logic             tick, irq, ovr, busy, cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             rst, st, sp, os;
    logic [WIDTH-1:0] tm;
    logic             rc, ld, ak;
    logic [WIDTH-1:0] e_cnt;
    logic             e_tick, e_irq, e_ovr, e_busy, e_cerr;
  } vec_t;

  vec_t vecs[$];

  rco_event_timer #(.WIDTH(WIDTH)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop),
    .oneshot_i(oneshot), .term_i(term), .rco_i(rco), .load_i(load),
    .ack_i(ack), .count_o(count), .tick_o(tick), .irq_o(irq),
    .ovr_o(ovr), .busy_o(busy), .cfg_err_o(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic add(input logic rst, st, sp, os, input logic [WIDTH-1:0] tm,
                     input logic rc, ld, ak, input logic [WIDTH-1:0] c,
                     input logic tk, iq, ov, bs, ce);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.os = os; v.tm = tm;
    v.rc = rc; v.ld = ld; v.ak = ak;
    v.e_cnt = c; v.e_tick = tk; v.e_irq = iq; v.e_ovr = ov;
    v.e_busy = bs; v.e_cerr = ce;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, st, sp, os, input logic [WIDTH-1:0] tm,
                       input logic rc, ld, ak);
    reset = rst; start = st; stop = sp; oneshot = os; term = tm;
    rco = rc; load = ld; ack = ak;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WIDTH+4:0] act,
                       input logic [WIDTH+4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {cnt,tick,irq,ovr,busy,cerr}=%h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [WIDTH+4:0] outs();
    return {count, tick, irq, ovr, busy, cfg_err};
  endfunction

  initial begin
    reset = 1'b1; start = 0; stop = 0; oneshot = 0; term = '0;
    rco = 0; load = 0; ack = 0;

    //   rst st sp os term   rc ld ak | cnt tk iq ov bs ce
    add(1, 0, 0, 0, 8'd0,  0, 0, 0,  8'd0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 8'd5,  1, 1, 1,  8'd0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'd0,  1, 0, 0,  8'd0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'd0,  0, 0, 0,  8'd0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 8'd0,  0, 0, 0,  8'd0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8'd3,  0, 0, 0,  8'd0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'd3,  0, 0, 0,  8'd0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'd3,  1, 0, 0,  8'd1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 8'd5,  0, 0, 0,  8'd1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'd5,  1, 0, 0,  8'd2, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'd5,  1, 0, 0,  8'd0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8'd5,  0, 0, 0,  8'd0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8'd5,  1, 0, 0,  8'd1, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8'd5,  1, 0, 0,  8'd2, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8'd5,  1, 1, 0,  8'd0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8'd5,  1, 0, 0,  8'd1, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8'd5,  1, 0, 0,  8'd2, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 8'd5,  1, 0, 0,  8'd0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'd5,  0, 0, 1,  8'd0, 0, 0, 0, 0, 0);
    // one-shot into DONE, then restart from DONE in periodic mode with term=1
    add(0, 1, 0, 1, 8'd2,  0, 0, 0,  8'd0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'd2,  1, 0, 0,  8'd1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'd2,  1, 0, 0,  8'd0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'd2,  1, 0, 0,  8'd0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 8'd1,  0, 0, 1,  8'd0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'd1,  1, 0, 0,  8'd0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8'd1,  1, 0, 0,  8'd0, 1, 1, 1, 1, 0);
    add(0, 0, 0, 0, 8'd1,  0, 0, 0,  8'd0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 8'd1,  0, 0, 1,  8'd0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'd1,  1, 0, 1,  8'd0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8'd1,  1, 0, 1,  8'd0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8'd1,  1, 0, 0,  8'd0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 0, 8'd1,  0, 0, 0,  8'd0, 0, 1, 1, 0, 0);
    // reset mid-RUN aborts without a TICK
    add(0, 1, 0, 0, 8'd4,  0, 0, 1,  8'd0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'd4,  1, 0, 0,  8'd1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 8'd4,  1, 0, 0,  8'd0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].os, vecs[i].tm,
            vecs[i].rc, vecs[i].ld, vecs[i].ak);
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].e_cnt, vecs[i].e_tick, vecs[i].e_irq, vecs[i].e_ovr,
             vecs[i].e_busy, vecs[i].e_cerr});
    end

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), WIDTH'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      check($sformatf("rand_reset%0d", i), outs(), '0);
    end
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 8'd0, 1, 0, 0);
    check("idle_rco_no_count", outs(), '0);

    // Periodic TERM=3 with an RCO every 16 cycles
    drive(0, 1, 0, 0, 8'd3, 0, 0, 0);
    check("per_start", outs(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int p = 1; p <= 9; p++) begin
      logic [WIDTH-1:0] ec;
      logic et;
      ec = WIDTH'(p % 3);
      et = (p % 3 == 0);
      drive(0, 0, 0, 0, 8'd3, 1, 0, 0);
      check($sformatf("per_rco%0d", p), outs(),
            {ec, et, (p >= 3) ? 1'b1 : 1'b0, (p >= 6) ? 1'b1 : 1'b0, 1'b1, 1'b0});
      for (int k = 0; k < 15; k++) drive(0, 0, 0, 0, 8'd3, 0, 0, 0);
      check($sformatf("per_gap%0d", p), outs(),
            {ec, 1'b0, (p >= 3) ? 1'b1 : 1'b0, (p >= 6) ? 1'b1 : 1'b0, 1'b1, 1'b0});
    end

    // Maximum terminal value
    drive(1, 0, 0, 0, 8'd0, 0, 0, 0);
    drive(0, 1, 0, 0, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 254; i++) drive(0, 0, 0, 0, 8'hFF, 1, 0, 0);
    check("max_254", outs(), {8'd254, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    drive(0, 0, 0, 0, 8'hFF, 1, 0, 0);
    check("max_255", outs(), {8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    drive(0, 0, 0, 0, 8'hFF, 0, 0, 0);
    check("max_after", outs(), {8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rco_event_timer.md
Name: rco_event_timer

Overview:
Downstream stage of the 4-bit counter (counter4b). Consumes the counter's RCO and LOAD outputs and counts RCO pulses up to a programmable terminal value, so a 4-bit counter plus this block acts as a two-level prescaled timer. On each terminal match it raises a one-cycle TICK and sets a sticky interrupt flag. It runs in periodic or one-shot mode and flags overruns when software has not acknowledged the previous interrupt.

Parameters:
WIDTH, 8, width of the RCO event counter and terminal value.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  arm request; sampled in IDLE/DONE only.
STOP  input  1  abort request; returns the block to IDLE.
ONESHOT  input  1  mode select, latched on accepted START (1 = one-shot, 0 = periodic).
TERM  input  WIDTH  terminal event count, latched on accepted START.
RCO  input  1  ripple-carry pulse from counter4b.
LOAD  input  1  counter4b load indicator; resynchronises the event count.
ACK  input  1  clears IRQ and OVR.
COUNT  output  WIDTH  current RCO event count.
TICK  output  1  one-cycle pulse on terminal match.
IRQ  output  1  sticky terminal flag.
OVR  output  1  sticky overrun flag.
BUSY  output  1  high while in RUN.
CFG_ERR  output  1  one-cycle pulse when START is rejected.

Behaviour:
- All outputs are registered. RESET=1 forces state IDLE, COUNT=0, TICK=0, IRQ=0, OVR=0, BUSY=0, CFG_ERR=0, term_q=0, oneshot_q=0. RESET overrides every other input. Reset mid-RUN aborts with no TICK.
- States: IDLE, RUN, DONE.
- IDLE/DONE handling:
  - START=1 with TERM!=0: latch term_q=TERM and oneshot_q=ONESHOT, clear COUNT, go to RUN. BUSY=1 from the next cycle.
  - START=1 with TERM==0: stay in the current state and pulse CFG_ERR for one cycle.
  - START and STOP both high: STOP wins, state becomes or stays IDLE, no CFG_ERR.
  - DONE behaves like IDLE except for its state encoding. DONE holds COUNT=0, BUSY=0.
- RUN priority per cycle (highest first):
  1. STOP: go to IDLE, COUNT←0, no TICK.
  2. LOAD: COUNT←0, no TICK, RCO in the same cycle is ignored.
  3. RCO with COUNT==term_q-1: COUNT←0, TICK=1 next cycle, IRQ←1. If IRQ was already 1 and ACK is not asserted in the same cycle, OVR←1. If oneshot_q=1, go to DONE; otherwise stay in RUN.
  4. RCO otherwise: COUNT←COUNT+1.
  5. No RCO: hold COUNT.
- Latency: RCO sampled at edge N; COUNT and TICK are valid after edge N. TICK is exactly one cycle wide. Back-to-back matches are possible only when term_q=1; in that case TICK stays high on consecutive cycles.
- term_q=1 means every RCO produces a TICK.
- COUNT never exceeds term_q-1, so no wrap past the terminal. term_q=2^WIDTH-1 is the maximum.
- START in RUN is ignored. TERM and ONESHOT changes in RUN have no effect until the next accepted START.
- ACK clears IRQ and OVR. If ACK coincides with a terminal match, the set wins: IRQ=1 and OVR stays 0.
- RCO and LOAD are in the CLK domain and need no synchroniser.

Test Plan:
- Reset: RESET=1 for 2 cycles with random inputs -> all outputs 0, state IDLE. After release with no START, 20 RCO pulses -> COUNT stays 0.
- Periodic: TERM=3, ONESHOT=0, START, then RCO every 16 cycles (counter4b free-running up) -> COUNT 0,1,2,0…; TICK one cycle after every 3rd RCO; IRQ=1; BUSY=1 throughout.
- One-shot and DONE: TERM=2, ONESHOT=1 -> one TICK after the 2nd RCO, then DONE with BUSY=0 and COUNT=0. Further RCO gives no TICK. A new START re-enters RUN.
- Overrun and ACK: TERM=1, periodic, no ACK -> IRQ=1 on the 1st RCO, OVR=1 on the 2nd. ACK in a non-match cycle -> IRQ=0, OVR=0. ACK coinciding with RCO -> IRQ=1, OVR=0.
- Priority: in RUN with COUNT=term_q-1, assert LOAD and RCO together -> COUNT=0, no TICK. Assert STOP and RCO together -> IDLE, no TICK, COUNT=0.
- Config error: START with TERM=0 -> CFG_ERR pulses one cycle, state stays IDLE, BUSY=0. START with TERM=8'hFF -> TICK after the 255th RCO.
